// File: rtl/cmu_multi.sv
// Multi-channel clock management unit: per-channel RUN/DRAIN/STOPPED/WAKE gating FSM
// with glitch-free latch-based clock gates. Define CMU_STATS_EN to add per-channel stopped-cycle counters.
module cmu_multi #(
    parameter int NCH      = 4,
    parameter int STOP_DLY = 2,
    parameter int WAKE_DLY = 1
) (
    input  logic                clk_in,
    input  logic                rst_n,
    input  logic [NCH-1:0]      stop,
    input  logic [NCH-1:0]      resume_n,
    input  logic                force_run,
    output logic [NCH-1:0]      clk_out,
    output logic [NCH-1:0]      stopped,
    output logic [NCH-1:0]      busy
`ifdef CMU_STATS_EN
    ,
    output logic [16*NCH-1:0]   stop_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_STOPPED = 2'd2,
        ST_WAKE    = 2'd3
    } state_e;

    localparam logic [3:0] STOP_LOAD = (STOP_DLY > 0) ? 4'(STOP_DLY - 1) : 4'd0;
    localparam logic [3:0] WAKE_LOAD = (WAKE_DLY > 0) ? 4'(WAKE_DLY - 1) : 4'd0;

    for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
        state_e     state_q, state_d;
        logic [3:0] cnt_q, cnt_d;
        logic       stopped_q, stopped_d;
        logic       busy_q, busy_d;
        logic       en;
        logic       en_lat;

        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            stopped_d = (state_q == ST_STOPPED);
            busy_d    = (state_q == ST_DRAIN) || (state_q == ST_WAKE);
            if (force_run) begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end else begin
                case (state_q)
                    ST_RUN: begin
                        if (stop[ch] && resume_n[ch]) begin
                            if (STOP_DLY == 0) begin
                                state_d = ST_STOPPED;
                            end else begin
                                state_d = ST_DRAIN;
                                cnt_d   = STOP_LOAD;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        if (!stop[ch] || !resume_n[ch]) begin
                            state_d = ST_RUN;
                            cnt_d   = '0;
                        end else if (cnt_q == 4'd0) begin
                            state_d = ST_STOPPED;
                        end else begin
                            cnt_d = cnt_q - 4'd1;
                        end
                    end
                    ST_STOPPED: begin
                        if (!resume_n[ch] || !stop[ch]) begin
                            state_d = ST_WAKE;
                            cnt_d   = WAKE_LOAD;
                        end
                    end
                    ST_WAKE: begin
                        if (cnt_q == 4'd0) begin
                            state_d = ST_RUN;
                        end else begin
                            cnt_d = cnt_q - 4'd1;
                        end
                    end
                    default: begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end
                endcase
            end
        end

        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        always_ff @(posedge clk_in) begin
            if (!rst_n) begin
                state_q   <= ST_RUN;
                cnt_q     <= '0;
                stopped_q <= 1'b0;
                busy_q    <= 1'b0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                stopped_q <= stopped_d;
                busy_q    <= busy_d;
            end
        end

        // Gate is closed if the channel is STOPPED on either side of the coming edge, so the
        // edge entering STOPPED delivers no pulse and the edge leaving it delivers none either.
        assign en = (state_q != ST_STOPPED) && (!rst_n || (state_d != ST_STOPPED));

        // NOTE: intentional level-sensitive latch, transparent while clk_in is low; it holds en
        // stable through the high phase so the AND gate can neither glitch nor truncate a pulse.
        always_latch begin
            if (!clk_in) en_lat = en;
        end

        assign clk_out[ch] = clk_in & en_lat;
        assign stopped[ch] = stopped_q;
        assign busy[ch]    = busy_q;

`ifdef CMU_STATS_EN
        logic [15:0] scnt_q, scnt_d;

        always_comb begin
            scnt_d = scnt_q;
            if ((state_q == ST_STOPPED) && (scnt_q != 16'hFFFF)) scnt_d = scnt_q + 16'd1;
        end

        always_ff @(posedge clk_in) begin
            if (!rst_n) scnt_q <= '0;
            else        scnt_q <= scnt_d;
        end

        assign stop_cnt[16*ch +: 16] = scnt_q;
`endif
    end

endmodule

// File: tb/tb_cmu_multi.sv
// Scoreboard bench for cmu_multi: a per-channel behavioural model predicts pulses and status
// each edge; a separate monitor compares. Works with or without CMU_STATS_EN.
module tb_cmu_multi;

    localparam int NCH      = 4;
    localparam int STOP_DLY = 2;
    localparam int WAKE_DLY = 1;
    localparam logic [NCH-1:0] ALL1 = {NCH{1'b1}};

    logic               clk_in = 1'b0;
    logic               rst_n;
    logic [NCH-1:0]     stop;
    logic [NCH-1:0]     resume_n;
    logic               force_run;
    logic [NCH-1:0]     clk_out;
    logic [NCH-1:0]     stopped;
    logic [NCH-1:0]     busy;
`ifdef CMU_STATS_EN
    logic [16*NCH-1:0]  stop_cnt;
`endif

    always #5 clk_in = ~clk_in;

    cmu_multi #(.NCH(NCH), .STOP_DLY(STOP_DLY), .WAKE_DLY(WAKE_DLY)) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .stop      (stop),
        .resume_n  (resume_n),
        .force_run (force_run),
        .clk_out   (clk_out),
        .stopped   (stopped),
        .busy      (busy)
`ifdef CMU_STATS_EN
        ,
        .stop_cnt  (stop_cnt)
`endif
    );

    typedef struct {
        logic [NCH-1:0]    clk_hi;
        logic [NCH-1:0]    stopped;
        logic [NCH-1:0]    busy;
        logic [16*NCH-1:0] scnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   armed    = 1'b0;

    // Model: a channel is either running, draining (pulses left), stopped, or waking (cycles left).
    bit m_stopped[NCH];
    int m_drain[NCH];
    int m_wake[NCH];
    int m_scnt[NCH];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic exp_t model_edge(input logic r, input logic f,
                                        input logic [NCH-1:0] s, input logic [NCH-1:0] rn);
        exp_t e;
        for (int ch = 0; ch < NCH; ch++) begin
            bit was_stop = m_stopped[ch];
            bit was_busy = (m_drain[ch] > 0) || (m_wake[ch] > 0);
            if (!r || f) begin
                m_stopped[ch] = 1'b0;
                m_drain[ch]   = 0;
                m_wake[ch]    = 0;
            end else if (m_wake[ch] > 0) begin
                m_wake[ch]--;
            end else if (m_drain[ch] > 0) begin
                if (!s[ch] || !rn[ch]) begin
                    m_drain[ch] = 0;
                end else begin
                    m_drain[ch]--;
                    if (m_drain[ch] == 0) m_stopped[ch] = 1'b1;
                end
            end else if (m_stopped[ch]) begin
                if (!rn[ch] || !s[ch]) begin
                    m_stopped[ch] = 1'b0;
                    m_wake[ch]    = WAKE_DLY;
                end
            end else if (s[ch] && rn[ch]) begin
                if (STOP_DLY == 0) m_stopped[ch] = 1'b1;
                else               m_drain[ch]   = STOP_DLY;
            end
            if (!r)                               m_scnt[ch] = 0;
            else if (was_stop && m_scnt[ch] < 65535) m_scnt[ch]++;
            e.stopped[ch]          = r ? was_stop : 1'b0;
            e.busy[ch]             = r ? was_busy : 1'b0;
            e.clk_hi[ch]           = !was_stop && !m_stopped[ch];
            e.scnt[16*ch +: 16]    = 16'(m_scnt[ch]);
        end
        return e;
    endfunction

    task automatic step(input logic r, input logic f, input logic [NCH-1:0] s, input logic [NCH-1:0] rn);
        exp_t e;
        @(negedge clk_in);
        #1;
        rst_n     = r;
        force_run = f;
        stop      = s;
        resume_n  = rn;
        @(posedge clk_in);
        e = model_edge(r, f, s, rn);
        #1;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk_in);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("clk_out_high", 64'(clk_out), 64'(e.clk_hi));
                check("stopped",      64'(stopped), 64'(e.stopped));
                check("busy",         64'(busy),    64'(e.busy));
`ifdef CMU_STATS_EN
                check("stop_cnt",     64'(stop_cnt), 64'(e.scnt));
`endif
            end
        end
    end

    always @(negedge clk_in) begin
        if (armed) begin
            #1;
            check("clk_out_low", 64'(clk_out), 64'd0);
        end
    end

    initial begin : stimulus
        logic [NCH-1:0] s_r;
        logic [NCH-1:0] rn_r;
        rst_n     = 1'b0;
        stop      = '0;
        resume_n  = ALL1;
        force_run = 1'b0;
        repeat (3) @(posedge clk_in);
        armed = 1'b1;

        step(1'b0, 1'b0, '0, ALL1);
        repeat (4) step(1'b1, 1'b0, '0, ALL1);
        repeat (6) step(1'b1, 1'b0, 4'b0001, ALL1);
        step(1'b1, 1'b0, 4'b0011, ALL1);
        step(1'b1, 1'b0, 4'b0001, ALL1);
        repeat (6) step(1'b1, 1'b0, ALL1, ALL1);
        step(1'b1, 1'b0, ALL1, 4'b1011);
        repeat (3) step(1'b1, 1'b0, ALL1, ALL1);
        repeat (6) step(1'b1, 1'b0, ALL1, ALL1);
        repeat (2) step(1'b1, 1'b1, ALL1, ALL1);
        repeat (6) step(1'b1, 1'b0, ALL1, ALL1);
        step(1'b0, 1'b0, ALL1, ALL1);
        repeat (3) step(1'b1, 1'b0, ALL1, ALL1);
        step(1'b1, 1'b0, ALL1, 4'b0111);
        repeat (2) step(1'b1, 1'b0, 4'b0111, ALL1);
        step(1'b1, 1'b0, '0, ALL1);
`ifdef CMU_STATS_EN
        repeat (66000) step(1'b1, 1'b0, ALL1, ALL1);
        step(1'b0, 1'b0, ALL1, ALL1);
`endif

        s_r = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                if ($urandom_range(7) == 0) s_r[ch] = ~s_r[ch];
                rn_r[ch] = ($urandom_range(15) != 0);
            end
            step(($urandom_range(127) != 0), ($urandom_range(63) == 0), s_r, rn_r);
        end

        repeat (2) @(posedge clk_in);
        #3;
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
